// File: rtl/ps2_dev_pkg.sv
// Shared types and helpers for the PS/2 device-side frame generator.
package ps2_dev_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    LOW,
    GAP,
    INHIBIT
  } state_t;

  localparam int FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

  // Bit value at frame position idx: start, data LSB first, parity, stop.
  function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
    logic value;
    value = 1'b1;
    if (idx == 4'd0) begin
      value = 1'b0;
    end else if (idx <= 4'd8) begin
      value = data[3'(idx - 4'd1)];
    end else if (idx == 4'd9) begin
      value = odd_parity(data);
    end
    return value;
  endfunction

endpackage

// File: rtl/ps2_dev_fifo.sv
// Byte FIFO with registered head read; head_valid marks when head_data
// holds the byte at the read pointer.
module ps2_dev_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  input  logic                       rd_en,
  output logic [7:0]                 head_data,
  output logic                       head_valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [7:0]    head_data_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          head_valid_reg;
  logic          push;
  logic          pop;

  assign push = wr_en && (count_reg != DEPTH_CNT);
  assign pop  = rd_en && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
    head_data_reg <= mem[rd_ptr_reg];
  end

  // A pop invalidates the head for one cycle while the new address is read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      head_valid_reg <= (count_reg != '0) && !pop;
    end
  end

  assign head_data  = head_data_reg;
  assign head_valid = head_valid_reg;
  assign count      = count_reg;

endmodule

// File: rtl/ps2_dev_gen.sv
// PS/2 device-side transmitter: queues scan-code bytes and clocks them out
// as 11-bit frames, backing off and retransmitting when the host inhibits.
module ps2_dev_gen
  import ps2_dev_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int HALF_PERIOD = 40,
  parameter int GAP_CYCLES  = 200,
  parameter int CNT_W       = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          wr_valid_i,
  input  logic [7:0]                    wr_data_i,
  output logic                          wr_ready_o,
  input  logic                          ps2_clk_i,
  output logic                          ps2_clk_oe_o,
  output logic                          ps2_dat_oe_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
  output logic [CNT_W-1:0]              abort_cnt_o
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int PH_W  = $clog2(HALF_PERIOD);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CW-1:0]    DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(HALF_PERIOD - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST  = 4'(FRAME_BITS - 1);

  state_t           state_reg, state_next;
  logic [3:0]       bit_idx_reg, bit_idx_next;
  logic [PH_W-1:0]  phase_cnt_reg, phase_cnt_next;
  logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [CNT_W-1:0] abort_cnt_reg, abort_cnt_next;
  logic             sync1_reg, sync2_reg;
  logic             pop;
  logic [7:0]       head_data;
  logic             head_valid;
  logic [CW-1:0]    fifo_cnt;

  ps2_dev_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk_i),
    .rst_n      (rst_n_i),
    .wr_en      (wr_valid_i && wr_ready_o),
    .wr_data    (wr_data_i),
    .rd_en      (pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .count      (fifo_cnt)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= ps2_clk_i;
      sync2_reg <= sync1_reg;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= IDLE;
      bit_idx_reg   <= '0;
      phase_cnt_reg <= '0;
      gap_cnt_reg   <= '0;
      abort_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      bit_idx_reg   <= bit_idx_next;
      phase_cnt_reg <= phase_cnt_next;
      gap_cnt_reg   <= gap_cnt_next;
      abort_cnt_reg <= abort_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_idx_next   = bit_idx_reg;
    phase_cnt_next = phase_cnt_reg;
    gap_cnt_next   = gap_cnt_reg;
    abort_cnt_next = abort_cnt_reg;
    pop            = 1'b0;
    case (state_reg)
      IDLE: begin
        bit_idx_next   = '0;
        phase_cnt_next = '0;
        gap_cnt_next   = '0;
        // A held-low clock means the host is inhibiting; honour the full
        // quiet period after it lets go before starting a frame.
        if (!sync2_reg) begin
          state_next = INHIBIT;
        end else if (head_valid) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (phase_cnt_reg == PH_LAST) begin
          phase_cnt_next = '0;
          if (!sync2_reg) begin
            state_next   = INHIBIT;
            bit_idx_next = '0;
            if (abort_cnt_reg != {CNT_W{1'b1}}) begin
              abort_cnt_next = abort_cnt_reg + 1'b1;
            end
          end else begin
            state_next = LOW;
          end
        end else begin
          phase_cnt_next = phase_cnt_reg + 1'b1;
        end
      end
      LOW: begin
        if (phase_cnt_reg == PH_LAST) begin
          phase_cnt_next = '0;
          if (bit_idx_reg == BIT_LAST) begin
            state_next   = GAP;
            bit_idx_next = '0;
            pop          = 1'b1;
          end else begin
            state_next   = SETUP;
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end else begin
          phase_cnt_next = phase_cnt_reg + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          gap_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      INHIBIT: begin
        if (!sync2_reg) begin
          gap_cnt_next = '0;
        end else if (gap_cnt_reg == GAP_LAST) begin
          gap_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ps2_clk_oe_o = (state_reg == LOW);
  assign ps2_dat_oe_o = ((state_reg == SETUP) || (state_reg == LOW)) &&
                        !frame_bit(head_data, bit_idx_reg);
  assign busy_o       = (state_reg != IDLE);
  assign fifo_cnt_o   = fifo_cnt;
  assign wr_ready_o   = (fifo_cnt != DEPTH_CNT);
  assign abort_cnt_o  = abort_cnt_reg;

endmodule

// File: tb/tb_ps2_dev_gen.sv
// Directed bench: open-drain PS/2 lines with pull-ups, host samples data on
// falling PS/2 clock edges; frames compared to hand-packed {stop,par,data,start}.
module tb_ps2_dev_gen;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       clk_oe;
  logic       dat_oe;
  logic       busy;
  logic [3:0] fifo_cnt;
  logic [7:0] abort_cnt;
  logic       host_pull;
  logic       clk_line;
  logic       dat_line;
  int         cyc;
  int         n_vec;
  int         n_miss;

  assign clk_line = ~(clk_oe | host_pull);
  assign dat_line = ~dat_oe;

  ps2_dev_gen #(
    .FIFO_DEPTH  (8),
    .HALF_PERIOD (4),
    .GAP_CYCLES  (8),
    .CNT_W       (8)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .wr_valid_i   (wr_valid),
    .wr_data_i    (wr_data),
    .wr_ready_o   (wr_ready),
    .ps2_clk_i    (clk_line),
    .ps2_clk_oe_o (clk_oe),
    .ps2_dat_oe_o (dat_oe),
    .busy_o       (busy),
    .fifo_cnt_o   (fifo_cnt),
    .abort_cnt_o  (abort_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Called at a negedge; presents one byte across exactly one rising edge.
  task automatic wr_byte(input logic [7:0] d, output bit acc);
    wr_valid = 1'b1;
    wr_data  = d;
    acc      = wr_ready;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic capture(output logic [10:0] bits, output int t_start, output int t_end,
                         output bit ok, output bit early_clk);
    int   nb;
    logic prev;
    nb = 0; prev = 1'b1; bits = '0; ok = 1'b0;
    t_start = -1; t_end = -1; early_clk = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (t_start < 0) begin
        if (clk_oe) early_clk = 1'b1;
        if (dat_oe) t_start = cyc;
      end
      if (t_start >= 0) begin
        if (prev && !clk_line && nb < 11) begin
          bits[nb] = dat_line;
          nb++;
        end
        if (nb == 11 && clk_line) begin
          t_end = cyc;
          ok = 1'b1;
          break;
        end
      end
      prev = clk_line;
    end
  endtask

  task automatic wait_idle(output int t);
    t = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic quiet_check(input string tag);
    int active;
    active = 0;
    repeat (8) begin
      @(negedge clk);
      if (clk_oe || dat_oe) active++;
    end
    chk(tag, 32'(active), 32'd0);
  endtask

  initial begin
    logic [10:0] bits;
    int   ts, te, ts2, te2, ti, falls, acc_cnt;
    bit   ok, early, acc, found;
    logic prev;

    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; host_pull = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_clk_oe", 32'(clk_oe), 32'd0);
    chk("rst_dat_oe", 32'(dat_oe), 32'd0);
    chk("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_abort_cnt", 32'(abort_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0x1C: bits 0,0,0,1,1,1,0,0,0,0,1
    wr_byte(8'h1C, acc);
    chk("1c_accept", 32'(acc), 32'd1);
    chk("1c_fifo_cnt", 32'(fifo_cnt), 32'd1);
    capture(bits, ts, te, ok, early);
    chk("1c_frame_ok", 32'(ok), 32'd1);
    chk("1c_bits", 32'(bits), 32'h438);
    chk("1c_frame_len", 32'(te - ts), 32'd88);
    wait_idle(ti);
    chk("1c_busy_fall", 32'(ti - te), 32'd8);
    chk("1c_fifo_empty", 32'(fifo_cnt), 32'd0);

    // 0x00 then 0xFF back-to-back: both parity 1
    wr_byte(8'h00, acc);
    wr_byte(8'hFF, acc);
    capture(bits, ts, te, ok, early);
    chk("00_bits", 32'(bits), 32'h600);
    capture(bits, ts2, te2, ok, early);
    chk("ff_bits", 32'(bits), 32'h7FE);
    chk("ff_no_clk_in_gap", 32'(early), 32'd0);
    chk("gap_ge_8", 32'((ts2 - te) >= 8), 32'd1);
    wait_idle(ti);
    chk("00ff_idle", 32'(ti >= 0), 32'd1);

    // Host holds clock low: fill the FIFO, no frame may start
    host_pull = 1'b1;
    repeat (4) @(negedge clk);
    acc_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      wr_byte(8'(i), acc);
      if (acc) acc_cnt++;
    end
    chk("fill_accepts", 32'(acc_cnt), 32'd8);
    chk("fill_fifo_cnt", 32'(fifo_cnt), 32'd8);
    chk("fill_wr_ready", 32'(wr_ready), 32'd0);
    wr_byte(8'h09, acc);
    chk("ninth_accept", 32'(acc), 32'd0);
    chk("ninth_fifo_cnt", 32'(fifo_cnt), 32'd8);
    chk("held_dat_oe", 32'(dat_oe), 32'd0);
    host_pull = 1'b0;
    quiet_check("release_quiet");
    capture(bits, ts, te, ok, early);
    chk("q1_bits", 32'(bits), 32'h402);
    capture(bits, ts, te, ok, early);
    chk("q2_bits", 32'(bits), 32'h404);
    chk("q2_fifo_cnt", 32'(fifo_cnt), 32'd6);

    // Reset during LOW of bit 3 of the third frame
    falls = 0; prev = 1'b1; found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (prev && !clk_line) falls++;
      prev = clk_line;
      if (falls == 4) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_pre_low", 32'(found && clk_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_clk_oe", 32'(clk_oe), 32'd0);
    chk("midrst_dat_oe", 32'(dat_oe), 32'd0);
    chk("midrst_fifo_cnt", 32'(fifo_cnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wr_ready", 32'(wr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr_byte(8'h5A, acc);
    chk("lat_e0", 32'(dat_oe), 32'd0);
    @(negedge clk);
    chk("lat_e1", 32'(dat_oe), 32'd0);
    @(negedge clk);
    chk("lat_e2_start", 32'(dat_oe), 32'd1);
    wait_idle(ti);
    chk("lat_idle", 32'(ti >= 0), 32'd1);

    // Host inhibits during SETUP of bit 5 of 0xA5
    wr_byte(8'hA5, acc);
    falls = 0; prev = 1'b1; found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (prev && !clk_line) falls++;
      prev = clk_line;
      if (falls == 5 && !clk_oe) begin
        host_pull = 1'b1;
        found = 1'b1;
        break;
      end
    end
    chk("abort_reach_bit5", 32'(found), 32'd1);
    repeat (6) @(negedge clk);
    chk("abort_cnt", 32'(abort_cnt), 32'd1);
    chk("abort_clk_oe", 32'(clk_oe), 32'd0);
    chk("abort_dat_oe", 32'(dat_oe), 32'd0);
    chk("abort_fifo_cnt", 32'(fifo_cnt), 32'd1);
    host_pull = 1'b0;
    quiet_check("abort_release_quiet");
    capture(bits, ts, te, ok, early);
    chk("retx_ok", 32'(ok), 32'd1);
    chk("retx_bits", 32'(bits), 32'h74A);
    chk("retx_len", 32'(te - ts), 32'd88);
    wait_idle(ti);
    chk("retx_fifo_empty", 32'(fifo_cnt), 32'd0);
    chk("retx_abort_cnt", 32'(abort_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ps2_dev_gen.md
PS2_DEV_GEN -- requirements
Module: ps2_dev_gen

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, number of queued scan-code bytes; SHALL be a power of 2 and at least 2.
REQ-002 Parameter HALF_PERIOD, default 40, clk_i cycles per PS/2 clock half-period; SHALL be at least 3.
REQ-003 Parameter GAP_CYCLES, default 200, minimum idle cycles between frames and after a host inhibit ends.
REQ-004 Parameter CNT_W, default 8, width of abort_cnt_o.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk_i  in  1  block clock; all state updates on the rising edge.
REQ-007 rst_n_i  in  1  asynchronous active-low reset.
REQ-008 wr_valid_i  in  1  byte-write request.
REQ-009 wr_data_i  in  8  scan-code byte to queue.
REQ-010 wr_ready_o  out  1  FIFO not full; a write occurs when wr_valid_i and wr_ready_o are both 1 at a clk_i edge.
REQ-011 ps2_clk_i  in  1  PS/2 clock line read-back (pulled-up bus).
REQ-012 ps2_clk_oe_o  out  1  1 drives the PS/2 clock line low; 0 releases it.
REQ-013 ps2_dat_oe_o  out  1  1 drives the PS/2 data line low; 0 releases it.
REQ-014 busy_o  out  1  1 whenever the state is not IDLE.
REQ-015 fifo_cnt_o  out  $clog2(FIFO_DEPTH)+1  number of bytes queued, including the byte in flight.
REQ-016 abort_cnt_o  out  CNT_W  number of frames aborted by host inhibit; saturates at all-ones.

Function
REQ-017 Frame format SHALL be 11 bits: start 0, data[7:0] LSB first, odd parity, stop 1.
- Odd parity: the parity bit makes the count of ones in data plus parity odd.
- A bit value of 0 drives the line (dat_oe=1); a bit value of 1 releases it (dat_oe=0).
REQ-018 Each bit SHALL consist of two phases:
- SETUP: HALF_PERIOD cycles, clk_oe=0, data bit presented.
- LOW: HALF_PERIOD cycles, clk_oe=1, data bit held.
- The host samples on the falling clock edge; one frame lasts 22*HALF_PERIOD cycles.
REQ-019 State machine states: IDLE, SETUP, LOW, GAP, INHIBIT.
REQ-020 IDLE -> SETUP (bit 0) when the FIFO is non-empty and the synchronised clock line is high.
- The start-bit drive (dat_oe=1) SHALL be visible 2 cycles after the write edge into an empty, idle block.
REQ-021 SETUP -> LOW at the end of the phase. LOW -> SETUP (bit+1) for bits 0..9. LOW of bit 10 -> GAP.
- The byte SHALL be popped at the same edge LOW of bit 10 exits to GAP.
REQ-022 GAP lasts GAP_CYCLES with both outputs released, then the block returns to IDLE.
REQ-023 ps2_clk_i SHALL pass through a 2-flop synchroniser before any use.
REQ-024 Inhibit check: in the last cycle of every SETUP phase, a synchronised clock value of 0 SHALL abort the frame.
- On abort: release both lines, increment abort_cnt_o (saturating), go to INHIBIT.
- The FIFO head SHALL not be popped; the same byte is retransmitted from the start bit.
REQ-025 INHIBIT: wait until the synchronised clock has been high for GAP_CYCLES consecutive cycles, then go to IDLE.
- A low sample during this wait restarts the count.
REQ-026 In IDLE, a low synchronised clock line SHALL block frame start.
REQ-027 A simultaneous write and pop SHALL both take effect, leaving fifo_cnt_o unchanged.
- A write while full is impossible because wr_ready_o=0.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
- wr_ready_o SHALL equal (fifo_cnt_o != FIFO_DEPTH), derived from registered state.

Reset
REQ-029 Reset SHALL asynchronously force the following, regardless of mid-frame position:
- state=IDLE;
- ps2_clk_oe_o=0 and ps2_dat_oe_o=0;
- busy_o=0;
- fifo_cnt_o=0 (FIFO emptied);
- abort_cnt_o=0;
- bit index and phase/gap counters = 0;
- synchroniser flops = 1;
- wr_ready_o=1.
REQ-030 FIFO storage array contents SHALL not require reset.

Structure
REQ-031 Package ps2_dev_pkg SHALL hold the state enum typedef, FRAME_BITS=11, and a parity function.
REQ-032 One sub-module, ps2_dev_fifo (parametrised synchronous FIFO, width 8, depth FIFO_DEPTH, count output), SHALL hold byte storage.
REQ-033 The FSM, counters and synchroniser SHALL live in ps2_dev_gen.
- Outputs SHALL be driven from registers or decoded from registered state only.

Verification
REQ-034 Bench parameters: HALF_PERIOD=4, GAP_CYCLES=8, FIFO_DEPTH=8; the bench model pulls up both lines and samples data on the falling edges of clk.
REQ-035 Write 0x1C -> sampled bits 0,0,0,1,1,1,0,0,0,0,1; frame lasts 88 cycles; busy_o falls 8 cycles after the final rising edge.
REQ-036 Write 0x00 then 0xFF -> parity bit 1 for both; the frames are separated by at least 8 released cycles.
REQ-037 8 back-to-back writes with the host holding the clock low -> fifo_cnt_o=8, wr_ready_o=0; a 9th write is not accepted; no frame starts until the host releases the clock plus 8 cycles.
REQ-038 Host pulls the clock low during SETUP of bit 5 of 0xA5 -> abort_cnt_o=1, both oe=0, fifo_cnt_o unchanged; after release plus 8 cycles, the full 0xA5 frame is retransmitted.
REQ-039 Assert rst_n_i during LOW of bit 3 -> both oe=0 in the same cycle, fifo_cnt_o=0, busy_o=0; after release, a new write produces the start bit 2 cycles later.
